// File: rtl/arb_8ch_sched.sv
// 8-channel arbiter with registered, held grant and a per-tenure hold limit.
// Define ARB_RR_EN to switch from fixed priority (7 highest) to round-robin.
module arb_8ch_sched #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       idle,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam bit HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LIMITED ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_t            state_q, state_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [2:0]        gnt_idx_q, gnt_idx_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]        last_idx_q, last_idx_d;
    logic [2:0]        win_idx;

    // Winner selection; only consulted in IDLE when en & |req.
`ifdef ARB_RR_EN
    // Walk from last_idx (lowest priority) upward so the closest channel below
    // last_idx, wrapping mod 8, is assigned last and therefore wins.
    always_comb begin
        win_idx = '0;
        for (int k = 8; k >= 1; k--) begin
            if (req[last_idx_q - 3'(k)]) begin
                win_idx = last_idx_q - 3'(k);
            end
        end
    end
`else
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                win_idx = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        hold_cnt_d = hold_cnt_q;
        last_idx_d = last_idx_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en && (|req)) begin
                    state_d          = S_GRANT;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_idx_d        = win_idx;
                    gnt_vld_d        = 1'b1;
                    hold_cnt_d       = '0;
                    last_idx_d       = win_idx;
                end
            end
            S_GRANT: begin
                // en drop and release both end the tenure silently and take
                // precedence over a coincident hold-limit hit.
                if (!en || !req[gnt_idx_q]) begin
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end else if (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST)) begin
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    gnt_idx_d  = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                gnt_d      = '0;
                gnt_idx_d  = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_idx_q <= last_idx_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;
    assign idle    = en & ~(|req);

`ifndef SYNTHESIS
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_vld_matches : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld_q == (|gnt_q));
    a_idx_zero    : assert property (@(posedge clk) disable iff (!rst_n) !gnt_vld_q |-> gnt_idx_q == 3'd0);
    a_idx_is_last : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld_q |-> gnt_idx_q == last_idx_q);
    a_idx_decodes : assert property (@(posedge clk) disable iff (!rst_n) gnt_vld_q |-> gnt_q[gnt_idx_q]);
`endif

endmodule

// File: tb/tb_arb_8ch_sched.sv
// Directed bench for arb_8ch_sched built with MAX_HOLD=4; expected grant order
// in the hold-limit rotation scenario follows whether ARB_RR_EN is defined.
module tb_arb_8ch_sched;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       idle;
    logic       timeout;
    logic [12:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    arb_8ch_sched #(
        .MAX_HOLD(4),
        .HOLD_W  (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .req    (req),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .gnt_vld(gnt_vld),
        .idle   (idle),
        .timeout(timeout)
    );

    // {gnt, gnt_idx, gnt_vld, timeout}
    assign obs = {gnt, gnt_idx, gnt_vld, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
        end
        n_checks++;
        if (idle !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_en0: got %b expected 0", idle);
        end
        en = 1'b1;
        #1;
        n_checks++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL idle_no_req: got %b expected 1", idle);
        end
        req = 8'h04;
        #1;
        n_checks++;
        if (idle !== 1'b0) begin
            n_fail++; $display("FAIL idle_with_req: got %b expected 0", idle);
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL no_req_no_grant: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_priority_release();
        en  = 1'b1;
        req = 8'h24;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t1_grant5: got %h expected %h", obs, {8'h20, 3'd5, 1'b1, 1'b0});
        end
        req = 8'h04;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t1_release: got %h expected %h", obs, 13'h0);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t1_grant2: got %h expected %h", obs, {8'h04, 3'd2, 1'b1, 1'b0});
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t1_release2: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_hold_limit();
        req = 8'h01;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL t2_held_c%0d: got %h expected %h", c, obs, {8'h01, 3'd0, 1'b1, 1'b0});
            end
        end
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL t2_timeout: got %h expected %h", obs, {8'h00, 3'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t2_regrant: got %h expected %h", obs, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t2_release: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_release_at_limit();
        req = 8'h01;
        repeat (4) @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL release_at_limit: got %h expected %h", obs, 13'h0);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL release_at_limit_after: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_enable();
        en  = 1'b0;
        req = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({obs, idle} !== 14'h0) begin
            n_fail++; $display("FAIL t3_en_low: got %h expected %h", {obs, idle}, 14'h0);
        end
        en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t3_grant7: got %h expected %h", obs, {8'h80, 3'd7, 1'b1, 1'b0});
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t3_en_drop: got %h expected %h", obs, 13'h0);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t3_en_drop_no_pulse: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_no_preempt();
        en  = 1'b1;
        req = 8'h08;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t4_grant3: got %h expected %h", obs, {8'h08, 3'd3, 1'b1, 1'b0});
        end
        req = 8'h88;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t4_no_preempt: got %h expected %h", obs, {8'h08, 3'd3, 1'b1, 1'b0});
        end
        req = 8'h80;
        @(negedge clk);
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t4_dead_cycle: got %h expected %h", obs, 13'h0);
        end
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t4_grant7: got %h expected %h", obs, {8'h80, 3'd7, 1'b1, 1'b0});
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [2:0] e_idx;
        logic [7:0] e_gnt;
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
`ifdef ARB_RR_EN
            e_idx = 3'(7 - t);
`else
            e_idx = 3'd7;
`endif
            e_gnt = 8'h00;
            e_gnt[e_idx] = 1'b1;
            @(negedge clk);
            n_checks++;
            if (obs !== {e_gnt, e_idx, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL t5_tenure%0d_grant: got %h expected %h", t, obs, {e_gnt, e_idx, 1'b1, 1'b0});
            end
            repeat (3) @(negedge clk);
            @(negedge clk);
            n_checks++;
            if (obs !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL t5_tenure%0d_timeout: got %h expected %h", t, obs, {8'h00, 3'd0, 1'b0, 1'b1});
            end
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        en  = 1'b1;
        req = 8'h10;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t6_grant4: got %h expected %h", obs, {8'h10, 3'd4, 1'b1, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL t6_async_clear: got %h expected %h", obs, 13'h0);
        end
        req = 8'h02;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL t6_grant1: got %h expected %h", obs, {8'h02, 3'd1, 1'b1, 1'b0});
        end
        req = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        test_reset();
        test_priority_release();
        test_hold_limit();
        test_release_at_limit();
        test_enable();
        test_no_preempt();
        test_rotation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
